// File: rtl/sk6812_rx_decoder.sv
// sk6812_rx_decoder
//   Single-wire NZR receiver for the SK6812 data line. Each high pulse on din
//   is measured in clk cycles and decoded as 0 or 1 by width; bits are
//   assembled MSB-first into BITS-wide words. A long low gap ends the frame.
//
// Ports
//   clk         system clock (200 MHz)
//   Rst_n       asynchronous active-low reset
//   din         asynchronous serial data line
//   word_out    last completed word, MSB = first received bit
//   word_valid  one-cycle pulse when word_out updates
//   frame_end   one-cycle pulse when the reset gap is detected
//   err         one-cycle pulse on glitch, over-long high, or partial word at frame end
//   busy        high whenever the decoder is not idle
//
// State table
//   state    | meaning
//   IDLE     | no frame in progress, waiting for the first rising edge
//   HIGH     | line high, measuring pulse width
//   LOW      | line low between bits, watching for the reset gap
//   ERR_WAIT | bad pulse seen, ignoring the line until a full reset gap

module sk6812_rx_decoder #(
  parameter int BITS       = 24,
  parameter int T_MIN_HIGH = 20,
  parameter int T_THRESH   = 170,
  parameter int T_MAX_HIGH = 400,
  parameter int T_RESET    = 16000,
  parameter int CW         = 16
) (
  input  logic            clk,
  input  logic            Rst_n,
  input  logic            din,
  output logic [BITS-1:0] word_out,
  output logic            word_valid,
  output logic            frame_end,
  output logic            err,
  output logic            busy
);

  localparam int BCW = $clog2(BITS + 1);

  localparam logic [CW-1:0]  LIM_MIN    = CW'(T_MIN_HIGH);
  localparam logic [CW-1:0]  LIM_THRESH = CW'(T_THRESH);
  localparam logic [CW-1:0]  LIM_OVER   = CW'(T_MAX_HIGH + 1);
  localparam logic [CW-1:0]  LIM_RESET  = CW'(T_RESET);
  localparam logic [BCW-1:0] FULL_CNT   = BCW'(BITS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HIGH     = 2'd1,
    LOW      = 2'd2,
    ERR_WAIT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q, s_d_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic [BITS-1:0] word_q, word_d;
  logic            word_valid_q, word_valid_d;
  logic            frame_end_q, frame_end_d;
  logic            err_q, err_d;

  logic s, rise, fall;
  logic low_done, over_long;

  assign s    = sync2_q;
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  // cnt_q is always the length of the run of s_d_q's level, so the width of
  // a finished high or low run is read straight off cnt_q on the edge cycle.
  assign low_done  = ~s_d_q & (cnt_q == LIM_RESET);
  assign over_long =  s_d_q & (cnt_q == LIM_OVER);

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      s_d_q   <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      s_d_q   <= sync2_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (rise || fall) begin
      cnt_d = CW'(1);
    end else if (cnt_q != {CW{1'b1}}) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      frame_end_q  <= frame_end_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    frame_end_d  = 1'b0;
    err_d        = 1'b0;

    // Word completion runs one cycle after the bit is shifted in; the line is
    // guaranteed to be low then, so it never collides with a fall or a gap.
    if (bit_cnt_q == FULL_CNT) begin
      word_d       = shift_q;
      word_valid_d = 1'b1;
      bit_cnt_d    = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (rise) state_d = HIGH;
      end

      HIGH: begin
        // over_long also covers a fall whose width is exactly T_MAX_HIGH+1.
        if (over_long) begin
          err_d   = 1'b1;
          state_d = ERR_WAIT;
        end else if (fall) begin
          if (cnt_q < LIM_MIN) begin
            err_d   = 1'b1;
            state_d = ERR_WAIT;
          end else begin
            shift_d   = {shift_q[BITS-2:0], (cnt_q >= LIM_THRESH)};
            bit_cnt_d = bit_cnt_q + BCW'(1);
            state_d   = LOW;
          end
        end
      end

      LOW: begin
        // A rise on the very cycle the gap completes starts the next frame.
        if (low_done) begin
          frame_end_d = 1'b1;
          err_d       = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          state_d     = rise ? HIGH : IDLE;
        end else if (rise) begin
          state_d = HIGH;
        end
      end

      ERR_WAIT: begin
        if (low_done) begin
          bit_cnt_d = '0;
          state_d   = rise ? HIGH : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign word_out   = word_q;
  assign word_valid = word_valid_q;
  assign frame_end  = frame_end_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sk6812_rx_decoder.sv
`timescale 1ns/1ps
// Bench for sk6812_rx_decoder. The reset gap is shortened so the whole run
// stays short; pulse widths keep the real encoder timing.
module tb_sk6812_rx_decoder;
  localparam int BITS  = 24;
  localparam int T_MIN = 20;
  localparam int T_TH  = 170;
  localparam int T_MAX = 400;
  localparam int T_RST = 500;
  localparam int GAP   = T_RST + 8;

  typedef struct packed {
    logic [1:0]      kind;
    logic [31:0]     cyc;
    logic [BITS-1:0] data;
  } ev_t;

  localparam logic [1:0] EV_WORD  = 2'd0;
  localparam logic [1:0] EV_FRAME = 2'd1;
  localparam logic [1:0] EV_ERR   = 2'd2;

  logic            clk = 1'b0;
  logic            Rst_n = 1'b1;
  logic            din = 1'b0;
  logic [BITS-1:0] word_out;
  logic            word_valid, frame_end, err, busy;

  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  // reference model state: pulse-level decode
  bit              m_err;
  int              m_bits;
  logic [BITS-1:0] m_word;

  sk6812_rx_decoder #(
    .BITS(BITS), .T_MIN_HIGH(T_MIN), .T_THRESH(T_TH), .T_MAX_HIGH(T_MAX),
    .T_RESET(T_RST), .CW(16)
  ) dut (
    .clk(clk), .Rst_n(Rst_n), .din(din), .word_out(word_out),
    .word_valid(word_valid), .frame_end(frame_end), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (Rst_n) begin
      if (word_valid) obs_q.push_back({EV_WORD, 32'(cyc), word_out});
      if (frame_end)  obs_q.push_back({EV_FRAME, 32'(cyc), {BITS{1'b0}}});
      if (err)        obs_q.push_back({EV_ERR, 32'(cyc), {BITS{1'b0}}});
    end
  end

  function automatic void expect_ev(logic [1:0] k, int c, logic [BITS-1:0] d);
    exp_q.push_back({k, 32'(c), d});
  endfunction

  function automatic void model_reset();
    m_err = 1'b0;
    m_bits = 0;
    m_word = '0;
  endfunction

  // Drive one high pulse of h cycles followed by l cycles low, starting just
  // after a falling clk edge. Event times: the width is resolved 2 cycles after
  // the line edge is driven; err/bit register one cycle later, the word one
  // cycle after that, and the gap is counted from the fall.
  task automatic pulse(int h, int l);
    int c_r, c_f;
    din = 1'b1;
    c_r = cyc;
    repeat (h) @(negedge clk);
    din = 1'b0;
    c_f = cyc;
    if (!m_err) begin
      if (h > T_MAX) begin
        expect_ev(EV_ERR, c_r + T_MAX + 4, '0);
        m_err = 1'b1;
      end else if (h < T_MIN) begin
        expect_ev(EV_ERR, c_f + 3, '0);
        m_err = 1'b1;
      end else begin
        m_word = (m_word << 1) | BITS'(h >= T_TH);
        m_bits++;
        if (m_bits == BITS) begin
          expect_ev(EV_WORD, c_f + 4, m_word);
          m_bits = 0;
        end
      end
    end
    if (l >= T_RST) begin
      if (!m_err) begin
        expect_ev(EV_FRAME, c_f + T_RST + 3, '0);
        if (m_bits != 0) expect_ev(EV_ERR, c_f + T_RST + 3, '0);
      end
      m_bits = 0;
      m_err = 1'b0;
    end
    repeat (l) @(negedge clk);
  endtask

  // mode 0: encoder timing; 1: random widths/lows; 2: boundary widths
  task automatic send_bits(logic [BITS-1:0] w, int n, int mode, int last_gap);
    for (int i = 0; i < n; i++) begin
      logic b;
      int h, l;
      b = w[BITS-1-i];
      case (mode)
        0: begin
          h = b ? 270 : 70;
          l = 336 - h;
        end
        1: begin
          h = b ? int'($urandom_range(T_MAX, T_TH)) : int'($urandom_range(T_TH-1, T_MIN));
          l = int'($urandom_range(60, 20));
        end
        default: begin
          if (b) h = ($urandom_range(1, 0) == 1) ? T_TH : T_MAX;
          else   h = ($urandom_range(1, 0) == 1) ? T_MIN : T_TH - 1;
          l = (i == 11) ? T_RST - 1 : 20;
        end
      endcase
      if (i == n - 1 && last_gap > 0) l = last_gap;
      pulse(h, l);
    end
  endtask

  task automatic test_reset();
    din = 1'b0;
    #1 Rst_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    tests++; if (word_out !== '0)    begin fails++; $display("FAIL rst_word_out: got %h, expected 0", word_out); end
    tests++; if (word_valid !== 1'b0) begin fails++; $display("FAIL rst_word_valid: got %b, expected 0", word_valid); end
    tests++; if (frame_end !== 1'b0)  begin fails++; $display("FAIL rst_frame_end: got %b, expected 0", frame_end); end
    tests++; if (err !== 1'b0)        begin fails++; $display("FAIL rst_err: got %b, expected 0", err); end
    tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    Rst_n = 1'b1;
    repeat (2 * T_RST + T_RST / 2) @(negedge clk);
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL idle_busy: got %b, expected 0", busy); end
    tests++; if (word_out !== '0)   begin fails++; $display("FAIL idle_word_out: got %h, expected 0", word_out); end
    tests++; if (obs_q.size() !== 0) begin fails++; $display("FAIL idle_events: got %0d events, expected 0", obs_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_frame();
    send_bits(24'hA5C30F, BITS, 0, GAP);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL frame_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL frame_ev%0d: got kind=%0d cyc=%0d data=%h, expected kind=%0d cyc=%0d data=%h", i, obs_q[i].kind, obs_q[i].cyc, obs_q[i].data, exp_q[i].kind, exp_q[i].cyc, exp_q[i].data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_threshold();
    for (int i = 0; i < BITS; i++) pulse(T_TH - 1, 336 - (T_TH - 1));
    for (int i = 0; i < BITS - 1; i++) pulse(T_TH, 336 - T_TH);
    pulse(T_TH, GAP);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL thresh_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL thresh_ev%0d: got kind=%0d cyc=%0d data=%h, expected kind=%0d cyc=%0d data=%h", i, obs_q[i].kind, obs_q[i].cyc, obs_q[i].data, exp_q[i].kind, exp_q[i].cyc, exp_q[i].data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bounds();
    send_bits(BITS'($urandom), BITS, 2, GAP);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL bounds_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL bounds_ev%0d: got kind=%0d cyc=%0d data=%h, expected kind=%0d cyc=%0d data=%h", i, obs_q[i].kind, obs_q[i].cyc, obs_q[i].data, exp_q[i].kind, exp_q[i].cyc, exp_q[i].data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    send_bits(BITS'($urandom), 5, 1, 0);
    pulse(10, 100);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy: got %b, expected 1", busy); end
    pulse(270, 66);
    pulse(5, 200);
    pulse(70, 266);
    pulse(270, GAP);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_idle: got %b, expected 0", busy); end
    send_bits(BITS'($urandom), BITS, 1, GAP);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL glitch_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL glitch_ev%0d: got kind=%0d cyc=%0d data=%h, expected kind=%0d cyc=%0d data=%h", i, obs_q[i].kind, obs_q[i].cyc, obs_q[i].data, exp_q[i].kind, exp_q[i].cyc, exp_q[i].data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_overlong();
    send_bits(BITS'($urandom), 3, 1, 0);
    pulse(T_MAX + 100, GAP);
    send_bits(BITS'($urandom), 3, 1, 0);
    pulse(T_MAX + 1, GAP);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL overlong_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL overlong_ev%0d: got kind=%0d cyc=%0d data=%h, expected kind=%0d cyc=%0d data=%h", i, obs_q[i].kind, obs_q[i].cyc, obs_q[i].data, exp_q[i].kind, exp_q[i].cyc, exp_q[i].data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_partial();
    send_bits(BITS'($urandom), 10, 1, GAP);
    send_bits(BITS'($urandom), BITS, 1, GAP);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL partial_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL partial_ev%0d: got kind=%0d cyc=%0d data=%h, expected kind=%0d cyc=%0d data=%h", i, obs_q[i].kind, obs_q[i].cyc, obs_q[i].data, exp_q[i].kind, exp_q[i].cyc, exp_q[i].data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    send_bits(BITS'($urandom), 12, 1, 0);
    Rst_n = 1'b0;
    #1;
    model_reset();
    tests++; if (word_out !== '0) begin fails++; $display("FAIL rstmid_word_out: got %h, expected 0", word_out); end
    tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
    tests++; if ({word_valid, frame_end, err} !== 3'b000) begin fails++; $display("FAIL rstmid_pulses: got %b, expected 000", {word_valid, frame_end, err}); end
    repeat (3) @(negedge clk);
    Rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_bits(BITS'($urandom), BITS, 1, GAP);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL rstmid_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL rstmid_ev%0d: got kind=%0d cyc=%0d data=%h, expected kind=%0d cyc=%0d data=%h", i, obs_q[i].kind, obs_q[i].cyc, obs_q[i].data, exp_q[i].kind, exp_q[i].cyc, exp_q[i].data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    send_bits(BITS'($urandom), BITS, 1, 0);
    send_bits(BITS'($urandom), BITS, 1, GAP);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL b2b_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_ev%0d: got kind=%0d cyc=%0d data=%h, expected kind=%0d cyc=%0d data=%h", i, obs_q[i].kind, obs_q[i].cyc, obs_q[i].data, exp_q[i].kind, exp_q[i].cyc, exp_q[i].data); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_threshold();
    test_bounds();
    test_glitch();
    test_overlong();
    test_partial();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sk6812_rx_decoder.md
Name: sk6812_rx_decoder

Overview:
- Single-wire NZR receiver for the SK6812 data line; the decode-side counterpart of our pulse-width bit encoder.
- Samples the data line on the 200 MHz system clock and classifies each high pulse as 0 or 1 by width.
- Assembles bits MSB-first into pixel words and flags the latch/reset gap.
- Used for loopback checking of our encoder output and for snooping the strip's DOUT chain.

Parameters:
- BITS, 24, bits per pixel word (24 GRB; 32 RGBW).
- T_MIN_HIGH, 20, minimum valid high width in clk cycles (100 ns); shorter is a glitch.
- T_THRESH, 170, high width >= T_THRESH decodes as 1, otherwise 0 (850 ns).
- T_MAX_HIGH, 400, high width > T_MAX_HIGH is an error (2 us).
- T_RESET, 16000, low time in clk cycles that ends a frame (80 us).
- CW, 16, width of the duration counter; must hold T_RESET.

Ports:
- clk  input  1  200 MHz clock (already decided).
- Rst_n  input  1  asynchronous, active-low reset (already decided).
- din  input  1  asynchronous serial data line.
- word_out  output  BITS  last completed word, MSB = first received bit.
- word_valid  output  1  one-cycle pulse when word_out updates.
- frame_end  output  1  one-cycle pulse on detection of the reset gap.
- err  output  1  one-cycle pulse on glitch, over-long high, or partial word at frame end.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (async, Rst_n low):
  - All outputs 0: word_out = 0, word_valid = frame_end = err = busy = 0.
  - Synchronizer flops 0, counter 0, bit_cnt 0, shift register 0, state IDLE.
  - Reset mid-word discards the partial word; no pulses are generated on release.
- Input path:
  - 2-flop synchronizer, then a third flop for edge detect.
  - s = synchronized din.
  - rise = s & ~s_d; fall = ~s & s_d.
- Duration counter:
  - Loads 1 on every edge of s and increments while s is stable.
  - Saturates at all-ones and never wraps.
- States:
  - IDLE: busy = 0. On rise -> HIGH.
  - HIGH: counts high width.
    - On fall, width W = counter value at the cycle before fall.
    - W < T_MIN_HIGH or W > T_MAX_HIGH: err pulse -> ERR_WAIT.
    - W > T_MAX_HIGH is also detected while still high, the cycle the counter exceeds T_MAX_HIGH; err fires once only.
    - Otherwise bit = (W >= T_THRESH). Shift the bit in at the LSB, bit_cnt += 1, go to LOW.
  - LOW: counts low width.
    - On rise -> HIGH.
    - When low count reaches T_RESET: frame_end pulse. If bit_cnt != 0, err pulses in the same cycle and bit_cnt is cleared. -> IDLE.
  - ERR_WAIT:
    - Ignores all pulses.
    - The low counter restarts on every rise.
    - When low count reaches T_RESET -> IDLE, with no frame_end and bit_cnt cleared.
- Word completion:
  - When the shifted bit makes bit_cnt == BITS: word_out <= full shift value, word_valid pulses, bit_cnt <= 0.
  - word_valid and word_out update 1 cycle after the fall-detect cycle, i.e. 4 clk edges after the first clk edge that samples din low.
  - word_out holds its value until the next completed word.
- Boundaries:
  - W == T_THRESH decodes as 1.
  - W == T_THRESH-1 decodes as 0.
  - W == T_MIN_HIGH is valid; W == T_MAX_HIGH is valid.
  - Low of T_RESET-1 followed by rise continues the current frame.
  - word_valid and frame_end never coincide: the final bit's fall precedes the gap by at least T_RESET cycles.
- Bit period (low time) is not checked. Any low < T_RESET is accepted.

Test Plan:
- Reset, then din idle low for 20000 cycles -> all outputs 0, busy 0, no frame_end (IDLE does not count).
- Frame 0xA5C30F sent with encoder timing (1: 270 high; 0: 70 high; 336-cycle period), then 16000 low:
  - exactly one word_valid with word_out = 0xA5C30F;
  - frame_end pulses 16000 cycles after the last fall;
  - err never asserts.
- Threshold sweep, 24 bits of width 169 then 24 of width 170 (period 336) -> word_out = 0x000000 then 0xFFFFFF.
- Glitch: 10-cycle high pulse mid-word:
  - err pulse, busy stays high;
  - further pulses are ignored until a 16000-cycle low, then IDLE;
  - the next full frame decodes correctly.
- Partial word (10 bits) then 16000 low -> frame_end and err in the same cycle, no word_valid, the following frame decodes from bit 0.
- Rst_n pulsed low after 12 bits -> outputs 0 immediately; after release, a full 24-bit frame yields the correct word.
